// File: rtl/kamikaze_imem_bridge.sv
// Fetch-side responder: serves 32-bit word fetches as two 16-bit external reads (low, then high).
// Define KAMIKAZE_IMEM_BUF_EN to add a one-entry word buffer that answers repeated fetches locally.
module kamikaze_imem_bridge #(
   parameter int AW = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          im_req_i,
   input  logic [31:0]   im_addr_i,
   output logic [31:0]   im_data_o,
   output logic          im_valid_o,
   output logic          im_busy_o,
   input  logic          flush_i,
   output logic [AW-1:0] ext_addr_o,
   output logic          ext_rd_o,
   input  logic [15:0]   ext_data_i,
   input  logic          ext_ack_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [AW-2:0] word_r, word_s;
   logic [15:0]   lo_r, lo_s;
   logic [31:0]   im_data_r, im_data_s;
   logic          im_valid_r, im_valid_s;
   logic          im_busy_r, im_busy_s;
   logic          ext_rd_r, ext_rd_s;
   logic [AW-1:0] ext_addr_r, ext_addr_s;
   logic          buf_wr_s;
   logic          hit_s;
   logic [31:0]   buf_rd_s;
   logic          unused_addr_s;

   assign unused_addr_s = ^{im_addr_i[31:AW+1], im_addr_i[1:0]};

`ifdef KAMIKAZE_IMEM_BUF_EN
   logic          buf_valid_r;
   logic [AW-2:0] buf_tag_r;
   logic [31:0]   buf_data_r;

   // A flush in the request cycle forces the miss path.
   assign hit_s    = buf_valid_r && (buf_tag_r == im_addr_i[AW:2]) && !flush_i;
   assign buf_rd_s = buf_data_r;

   // Word buffer: flush dominates a simultaneous fill.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         buf_valid_r <= 1'b0;
         buf_tag_r   <= {(AW-1){1'b0}};
         buf_data_r  <= 32'h0000_0000;
      end else if (flush_i) begin
         buf_valid_r <= 1'b0;
      end else if (buf_wr_s) begin
         buf_valid_r <= 1'b1;
         buf_tag_r   <= word_r;
         buf_data_r  <= {ext_data_i, lo_r};
      end else begin
         buf_valid_r <= buf_valid_r;
      end
   end
`else
   logic unused_flush_s;

   assign hit_s          = 1'b0;
   assign buf_rd_s       = 32'h0000_0000;
   assign unused_flush_s = flush_i;
`endif

   // Next-state and next-output logic for the fetch sequencer.
   always_comb begin
      state_s    = state_r;
      word_s     = word_r;
      lo_s       = lo_r;
      im_data_s  = im_data_r;
      ext_rd_s   = ext_rd_r;
      ext_addr_s = ext_addr_r;
      buf_wr_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (im_req_i) begin
               word_s = im_addr_i[AW:2];
               if (hit_s) begin
                  state_s   = ST_DONE;
                  im_data_s = buf_rd_s;
               end else begin
                  state_s    = ST_LO;
                  ext_addr_s = {im_addr_i[AW:2], 1'b0};
                  ext_rd_s   = 1'b1;
               end
            end else begin
               ext_rd_s = 1'b0;
            end
         end
         ST_LO: begin
            if (ext_ack_i) begin
               lo_s       = ext_data_i;
               ext_addr_s = {word_r, 1'b1};
               state_s    = ST_HI;
            end else begin
               state_s = ST_LO;
            end
         end
         ST_HI: begin
            if (ext_ack_i) begin
               im_data_s = {ext_data_i, lo_r};
               ext_rd_s  = 1'b0;
               buf_wr_s  = 1'b1;
               state_s   = ST_DONE;
            end else begin
               state_s = ST_HI;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s  = ST_IDLE;
            ext_rd_s = 1'b0;
         end
      endcase
      im_valid_s = (state_s == ST_DONE);
      im_busy_s  = (state_s != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r    <= ST_IDLE;
         word_r     <= {(AW-1){1'b0}};
         lo_r       <= 16'h0000;
         im_data_r  <= 32'h0000_0000;
         im_valid_r <= 1'b0;
         im_busy_r  <= 1'b0;
         ext_rd_r   <= 1'b0;
         ext_addr_r <= {AW{1'b0}};
      end else begin
         state_r    <= state_s;
         word_r     <= word_s;
         lo_r       <= lo_s;
         im_data_r  <= im_data_s;
         im_valid_r <= im_valid_s;
         im_busy_r  <= im_busy_s;
         ext_rd_r   <= ext_rd_s;
         ext_addr_r <= ext_addr_s;
      end
   end

   assign im_data_o  = im_data_r;
   assign im_valid_o = im_valid_r;
   assign im_busy_o  = im_busy_r;
   assign ext_rd_o   = ext_rd_r;
   assign ext_addr_o = ext_addr_r;

endmodule

// File: doc/kamikaze_imem_bridge.md
# kamikaze_imem_bridge

Instruction-memory responder on the memory side of the kamikaze fetch interface. It accepts 32-bit word fetch requests and serves each one by issuing two 16-bit reads on a narrow external bus (low halfword, then high halfword). It returns the assembled word with a one-cycle valid strobe. An optional one-entry word buffer returns repeated fetches of the same word without external traffic; this covers the misaligned 32-bit instruction case, where fetch re-reads a word.

## Interface
- AW, 16: external halfword address width; the word index is taken from im_addr_i[AW:2].
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- im_req_i  in  1  fetch request; sampled only in IDLE.
- im_addr_i  in  32  byte address of the fetch; bits [1:0] ignored; bits above AW ignored (aliasing).
- im_data_o  out  32  fetched word, {high halfword, low halfword}; holds its value between completions.
- im_valid_o  out  1  one-cycle strobe; im_data_o is valid in that cycle.
- im_busy_o  out  1  high in every state except IDLE.
- flush_i  in  1  invalidates the word buffer.
- ext_addr_o  out  AW  external halfword address.
- ext_rd_o  out  1  external read strobe; held high until acknowledged.
- ext_data_i  in  16  external read data; sampled when ext_acc_i is high.
- ext_ack_i  in  1  external acknowledge; may arrive in the same cycle ext_rd_o rises.

## Operation
- States: IDLE, LO, HI, DONE. All state, outputs and buffer are registered.
- IDLE with im_req_i=1:
  - Latch word index W = im_addr_i[AW:2].
  - On a buffer hit (macro defined, buffer valid, tag == W, flush_i=0): go to DONE and load im_data_o from the buffer.
  - Otherwise: go to LO with ext_addr_o={W,1'b0} and ext_rd_o=1.
- LO: hold ext_addr_o and ext_rd_o until ext_ack_i=1. On ack, capture ext_data_i into the low half, set ext_addr_o={W,1'b1} and go to HI with ext_rd_o still 1.
- HI: on ext_ack_i=1, capture ext_data_i into the high half, drive ext_rd_o=0, load im_data_o with the assembled word, and go to DONE.
- DONE: im_valid_o=1 for exactly this cycle; the next state is IDLE. im_req_i is not sampled in DONE.
- Address latching: im_addr_i and im_req_i are ignored outside IDLE. A request that drops mid-transaction still completes and still produces the valid strobe.
- ext_addr_o wraps: W at its maximum value gives the halfword pair {max,0} and {max,1}; there is no carry into other bits.
- Buffer update: on HI-ack, write the buffer tag W and the assembled data and set buffer valid, unless flush_i=1 in that same cycle. In that case the buffer stays invalid.
- flush_i clears buffer valid in any state. If flush_i and a request arrive together in IDLE, flush wins and the request is treated as a miss.
- Reset (asynchronous): state=IDLE; im_data_o=0; im_valid_o=0; im_busy_o=0; ext_rd_o=0; ext_addr_o=0; buffer invalid, tag 0. Reset mid-transaction abandons the read: ext_rd_o drops immediately and no valid strobe is produced.

## Timing
- Miss with zero-wait external memory (ack in the same cycle as rd): request accepted at edge 0; LO during cycle 1; HI during cycle 2; im_valid_o high in cycle 3. Request-to-valid is 3 cycles.
- Each external wait cycle adds one cycle per halfword. Latency = 3 + waits_lo + waits_hi.
- Hit: request accepted at edge 0; im_valid_o high in cycle 1 (1-cycle latency); no ext_rd_o pulse.
- Back-to-back: the earliest next acceptance is the IDLE cycle after DONE, giving a throughput of 1 word per 4 cycles on misses and 1 per 2 on hits.
- ext_rd_o is never low between the LO ack and HI; the two halfword reads are contiguous.

## Configuration
- KAMIKAZE_IMEM_BUF_EN defined: the one-entry word buffer is present and hits complete in 1 cycle; flush_i is functional.
- Not defined: there is no buffer or tag logic, every request takes the miss path, and flush_i is ignored (no effect).

## Test plan
- Zero-wait miss: memory halfwords 0x0013 at 0x0000 and 0x0000 at 0x0001; request im_addr_i=0x0 -> ext_addr_o 0x0000 then 0x0001, im_valid_o in cycle 3, im_data_o=0x00000013.
- Wait states: ack delayed by 2 cycles on each halfword, im_addr_i=0x8, halfwords 0x4537/0x1234 -> ext_addr_o 0x0004/0x0005, im_valid_o in cycle 7, im_data_o=0x12344537.
- Buffer hit (macro on): repeat im_addr_i=0x8, then im_addr_i=0xA -> both return 0x12344537 with 1-cycle latency and no ext_rd_o. With the macro off, each takes the 3+ cycle miss path.
- Flush: after the 0x8 miss, assert flush_i together with a request to 0x8 -> the request is treated as a miss (ext_rd_o asserted). A flush in the HI-ack cycle leaves the buffer invalid, so the next request to 0x8 also misses.
- Request drop and address change: pulse im_req_i for 1 cycle at 0x10, then change im_addr_i to 0x20 while in LO -> ext reads go to 0x0008/0x0009 and exactly one im_valid_o strobe occurs.
- Reset mid-HI: assert rst_i low while in HI -> ext_rd_o=0 and im_busy_o=0 immediately, im_valid_o never pulses, im_data_o=0, and the first request after reset misses.
